// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit: op codes, FSM states, default width.
// The ALU decodes its MUL/DIV rows with the same op_e encoding.
package muldiv_hilo_unit_pkg;

   localparam int unsigned MulDivWidth = 32;

   typedef enum logic [1:0] {
      OpMult  = 2'd0,
      OpMultu = 2'd1,
      OpDiv   = 2'd2,
      OpDivu  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2
   } state_e;

   function automatic logic op_is_signed(op_e op);
      return (op == OpMult) || (op == OpDiv);
   endfunction

   function automatic logic op_is_div(op_e op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/muldiv_hilo_unit_iter.sv
// One iteration of the multiply/divide datapath (combinational) plus operand magnitude helpers.
// Multiply: shift-add, {acc_hi, acc_lo} shifts right, acc_lo starts as the multiplier.
// Divide: restoring, acc_hi is the partial remainder, acc_lo shifts in quotient bits.
module muldiv_hilo_unit_iter
   import muldiv_hilo_unit_pkg::*;
#(
   parameter int unsigned Width = MulDivWidth
) (
   input  logic             is_signed_i,
   input  logic [Width-1:0] x_i,
   input  logic [Width-1:0] y_i,
   output logic [Width-1:0] mag_x_o,
   output logic [Width-1:0] mag_y_o,
   input  logic             is_div_i,
   input  logic [Width-1:0] acc_hi_i,
   input  logic [Width-1:0] acc_lo_i,
   input  logic [Width-1:0] operand_i,
   output logic [Width-1:0] acc_hi_o,
   output logic [Width-1:0] acc_lo_o
);

   // Absolute values; the most negative number maps onto itself, which is correct unsigned.
   always_comb begin
      mag_x_o = (is_signed_i && x_i[Width-1]) ? -x_i : x_i;
      mag_y_o = (is_signed_i && y_i[Width-1]) ? -y_i : y_i;
   end

   // Single shift-add or restore-subtract step.
   always_comb begin
      logic [Width:0]   sum;
      logic [Width:0]   shifted;
      logic [Width-1:0] diff;
      logic             ge;
      sum     = {1'b0, acc_hi_i} + {1'b0, (acc_lo_i[0] ? operand_i : '0)};
      shifted = {acc_hi_i, acc_lo_i[Width-1]};
      ge      = shifted >= {1'b0, operand_i};
      // When ge holds the true difference is below the divisor, so Width bits suffice.
      diff    = shifted[Width-1:0] - operand_i;
      if (is_div_i) begin
         acc_hi_o = ge ? diff : shifted[Width-1:0];
         acc_lo_o = {acc_lo_i[Width-2:0], ge};
      end else begin
         acc_hi_o = sum[Width:1];
         acc_lo_o = {sum[0], acc_lo_i[Width-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers and start/busy/done handshake.
// Build option: define MULDIV_FAST_MUL_EN to run MULT/MULTU as a single-cycle product
// (IDLE -> FIX -> IDLE); divides stay iterative in both builds.
module muldiv_hilo_unit
   import muldiv_hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MulDivWidth
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             flush_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_o
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e            state_q;
   op_e               op_q, op_in, op_sel;
   logic [WIDTH-1:0]  x_q, y_q, x_sel, y_sel;
   logic [WIDTH-1:0]  acc_hi_q, acc_lo_q, step_hi, step_lo, step_operand;
   logic [WIDTH-1:0]  mag_x, mag_y;
   logic [WIDTH-1:0]  hi_q, lo_q, fix_hi, fix_lo;
   logic [CntW-1:0]   cnt_q;
   logic              busy_q, done_q, div0_q;
   logic              sel_signed, sel_div, fix_div0;

   // In IDLE the helpers see the live inputs (to seed the accumulators), otherwise the latched ones.
   always_comb begin
      op_in        = op_e'(op_i);
      op_sel       = (state_q == StIdle) ? op_in : op_q;
      x_sel        = (state_q == StIdle) ? x_i : x_q;
      y_sel        = (state_q == StIdle) ? y_i : y_q;
      sel_signed   = op_is_signed(op_sel);
      sel_div      = op_is_div(op_sel);
      step_operand = sel_div ? mag_y : mag_x;
   end

   muldiv_hilo_unit_iter #(
      .Width (WIDTH)
   ) u_iter (
      .is_signed_i (sel_signed),
      .x_i         (x_sel),
      .y_i         (y_sel),
      .mag_x_o     (mag_x),
      .mag_y_o     (mag_y),
      .is_div_i    (sel_div),
      .acc_hi_i    (acc_hi_q),
      .acc_lo_i    (acc_lo_q),
      .operand_i   (step_operand),
      .acc_hi_o    (step_hi),
      .acc_lo_o    (step_lo)
   );

   // Sign correction and divide-by-zero override applied in FIX.
   always_comb begin
      logic [2*WIDTH-1:0] prod;
      logic [2*WIDTH-1:0] prod_res;
      logic               neg_res;
      prod = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_FAST_MUL_EN
      if (!op_is_div(op_q)) begin
         prod = {{WIDTH{1'b0}}, mag_x} * {{WIDTH{1'b0}}, mag_y};
      end
`endif
      neg_res  = op_is_signed(op_q) && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
      prod_res = neg_res ? -prod : prod;
      fix_div0 = op_is_div(op_q) && (y_q == '0);
      fix_hi   = prod_res[2*WIDTH-1:WIDTH];
      fix_lo   = prod_res[WIDTH-1:0];
      if (fix_div0) begin
         fix_hi = x_q;
         fix_lo = '1;
      end else if (op_is_div(op_q)) begin
         fix_lo = neg_res ? -acc_lo_q : acc_lo_q;
         fix_hi = (op_is_signed(op_q) && x_q[WIDTH-1]) ? -acc_hi_q : acc_hi_q;
      end
   end

   // Control FSM with registered HI/LO, busy, done and div0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= OpMult;
         x_q      <= '0;
         y_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (mthi_i) hi_q <= x_i;
               if (mtlo_i) lo_q <= x_i;
               if (start_i) begin
                  op_q     <= op_in;
                  x_q      <= x_i;
                  y_q      <= y_i;
                  acc_hi_q <= '0;
                  acc_lo_q <= op_is_div(op_in) ? mag_x : mag_y;
                  cnt_q    <= CntW'(WIDTH - 1);
                  busy_q   <= 1'b1;
                  div0_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                  state_q  <= op_is_div(op_in) ? StCalc : StFix;
`else
                  state_q  <= StCalc;
`endif
               end
            end
            StCalc: begin
               if (flush_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  acc_hi_q <= step_hi;
                  acc_lo_q <= step_lo;
                  cnt_q    <= cnt_q - CntW'(1);
                  if (cnt_q == '0) state_q <= StFix;
               end
            end
            StFix: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               // A flush here wins over the result write.
               if (!flush_i) begin
                  hi_q   <= fix_hi;
                  lo_q   <= fix_lo;
                  div0_q <= fix_div0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign div0_o = div0_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: the driver pushes reference results (plain 64-bit
// arithmetic) with their due cycle, a monitor pops and compares on every done pulse.
module tb_muldiv_hilo_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, flush_i, mthi_i, mtlo_i;
   logic [1:0]  op_i;
   logic [31:0] x_i, y_i;
   logic [31:0] hi_o, lo_o;
   logic        busy_o, done_o, div0_o;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_hi, m_lo, old_lo;
   logic        prev_done = 1'b0;

   muldiv_hilo_unit #(
      .WIDTH (32)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start_i),
      .op_i    (op_i),
      .x_i     (x_i),
      .y_i     (y_i),
      .flush_i (flush_i),
      .mthi_i  (mthi_i),
      .mtlo_i  (mtlo_i),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .div0_o  (div0_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: what HI/LO must hold after the op, from ordinary integer arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input int unsigned issue);
      exp_t        e;
      longint      sx, sy, q, r;
      logic [63:0] p, ux, uy;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'b0, x};
      uy = {32'b0, y};
      e.div0 = 1'b0;
      e.due  = issue + 34;
`ifdef MULDIV_FAST_MUL_EN
      if (op < 2) e.due = issue + 2;
`endif
      if (op == 2'd0) begin
         p = sx * sy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (op == 2'd1) begin
         p = ux * uy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == 32'd0) begin
         e.hi   = x;
         e.lo   = 32'hFFFF_FFFF;
         e.div0 = 1'b1;
      end else begin
         if (op == 2'd2) begin
            q = sx / sy;
            r = sx % sy;
         end else begin
            q = longint'(ux / uy);
            r = longint'(ux % uy);
         end
         p = q;
         e.lo = p[31:0];
         p = r;
         e.hi = p[31:0];
      end
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return $urandom_range(0, 255);
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_not_busy();
      int k = 0;
      while (busy_o) begin
         @(negedge clk);
         k++;
         if (k > 100) begin
            check("busy_timeout", 64'(busy_o), 64'd0);
            return;
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (sb.size() == 0 && !busy_o) return;
         @(negedge clk);
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   // Launch an op whose result is expected; operands are scrambled afterwards.
   task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      wait_not_busy();
      e = model(op, x, y, cyc);
      sb.push_back(e);
      m_hi    = e.hi;
      m_lo    = e.lo;
      start_i = 1'b1;
      op_i    = op;
      x_i     = x;
      y_i     = y;
      @(negedge clk);
      start_i = 1'b0;
      x_i     = $urandom;
      y_i     = $urandom;
      op_i    = 2'($urandom_range(0, 3));
   endtask

   // Launch an op that will be flushed or reset away (nothing expected).
   task automatic start_raw(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      wait_not_busy();
      start_i = 1'b1;
      op_i    = op;
      x_i     = x;
      y_i     = y;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest expected result, on its due cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done_o) begin
            check("done_back_to_back", 64'(prev_done), 64'd0);
            check("busy_at_done", 64'(busy_o), 64'd0);
            if (sb.size() == 0) begin
               check("unexpected_done", 64'(done_o), 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("hi", 64'(hi_o), 64'(mon_e.hi));
               check("lo", 64'(lo_o), 64'(mon_e.lo));
               check("div0", 64'(div0_o), 64'(mon_e.div0));
               check("done_cycle", 64'(cyc), 64'(mon_e.due));
            end
         end
         prev_done <= done_o;
      end else begin
         prev_done <= 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      start_i = 1'b0;
      flush_i = 1'b0;
      mthi_i  = 1'b0;
      mtlo_i  = 1'b0;
      op_i    = 2'd0;
      x_i     = 32'd0;
      y_i     = 32'd0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_div0", 64'(div0_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed ops, including overflow and divide-by-zero then div0 clear.
      issue(2'd0, 32'h0000_1249, 32'hFFFF_FF0F);
      issue(2'd1, 32'h0000_1249, 32'hFFFF_FF0F);
      issue(2'd2, 32'h0000_1249, 32'hFFFF_FF0F);
      issue(2'd3, 32'h0000_1249, 32'hFFFF_FF0F);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'd3, 32'd7, 32'd0);
      issue(2'd0, 32'd3, 32'hFFFF_FFFB);
      drain();
      check("idle_hi", 64'(hi_o), 64'(m_hi));
      check("idle_lo", 64'(lo_o), 64'(m_lo));

      // Flush mid-op: start during busy ignored, no done, HI/LO keep prior values.
      start_raw(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (2) @(negedge clk);
      start_i = 1'b1;
      op_i    = 2'd3;
      x_i     = 32'd7;
      y_i     = 32'd0;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_busy", 64'(busy_o), 64'd0);
      check("flush_done", 64'(done_o), 64'd0);
      repeat (40) @(negedge clk);
      check("flush_hi", 64'(hi_o), 64'(m_hi));
      check("flush_lo", 64'(lo_o), 64'(m_lo));

      // Flush in IDLE has no effect.
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("idle_flush_lo", 64'(lo_o), 64'(m_lo));

      // mthi in IDLE.
      mthi_i = 1'b1;
      x_i    = 32'hA5A5_A5A5;
      @(negedge clk);
      mthi_i = 1'b0;
      m_hi   = 32'hA5A5_A5A5;
      check("mthi", 64'(hi_o), 64'(m_hi));

      // mtlo and start while busy are both ignored; result lands on time.
      old_lo = m_lo;
      issue(2'd2, 32'hFFFF_FC19, 32'd7);
      repeat (3) @(negedge clk);
      mtlo_i = 1'b1;
      x_i    = 32'hDEAD_BEEF;
      @(negedge clk);
      mtlo_i  = 1'b0;
      start_i = 1'b1;
      op_i    = 2'd1;
      @(negedge clk);
      start_i = 1'b0;
      check("mtlo_busy_lo", 64'(lo_o), 64'(old_lo));
      check("mtlo_busy_busy", 64'(busy_o), 64'd1);
      drain();

      // start with mtlo in IDLE: LO written now, then overwritten by FIX.
      wait_not_busy();
      mtlo_i = 1'b1;
      issue(2'd1, 32'h0000_0077, 32'd3);
      mtlo_i = 1'b0;
      check("start_mtlo_lo", 64'(lo_o), 64'h77);
      drain();
      check("start_mtlo_final_lo", 64'(lo_o), 64'(m_lo));

      // Randomised ops with corner operands and random gaps.
      repeat (40) begin
         issue(2'($urandom_range(0, 3)), pick(), pick());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      drain();

      // Asynchronous reset mid-op clears everything at once.
      issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      drain();
      start_raw(2'd3, 32'h0000_0009, 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_hi", 64'(hi_o), 64'd0);
      check("arst_lo", 64'(lo_o), 64'd0);
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_done", 64'(done_o), 64'd0);
      check("arst_div0", 64'(div0_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("post_reset_busy", 64'(busy_o), 64'd0);
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
